// File: rtl/prio_irq_pkg.sv
// ---------------------------------------------------------------------------
// prio_irq_pkg
// Shared types for the registered priority interrupt encoder.
//   state_t : arbitration FSM state (IDLE = no grant held, ACTIVE = grant held)
// ---------------------------------------------------------------------------
package prio_irq_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage : prio_irq_pkg

// File: rtl/priority_encoder_param.sv
// ---------------------------------------------------------------------------
// priority_encoder_param
// Combinational highest-index-wins priority encoder (generalised 8-to-3).
// Ports:
//   vec : input  [N-1:0]     candidate lines, bit N-1 has highest priority
//   idx : output [IDX_W-1:0] index of highest set bit (0 when none set)
//   any : output             1 when at least one bit of vec is set
// ---------------------------------------------------------------------------
module priority_encoder_param #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Ascending scan: the last set bit seen is the highest index, so it wins.
   always_comb begin
      // NOTE: defaults first so every path assigns idx/any and no latch is inferred.
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule : priority_encoder_param

// File: rtl/prio_irq_encoder.sv
// ---------------------------------------------------------------------------
// prio_irq_encoder
// Captures N request lines into a sticky pending register, masks them, and
// presents the highest-index eligible line as a held interrupt until acked.
// Ports:
//   clk     : input           clock, all state on rising edge
//   rst_n   : input           asynchronous active-low reset
//   req     : input  [N-1:0]  request lines (edge or level per EDGE_MODE)
//   mask    : input  [N-1:0]  1 = line excluded from arbitration (still latched)
//   ack     : input           consumer acknowledge, honoured only while irq=1
//   irq     : output          interrupt valid (registered)
//   irq_id  : output [IDX_W-1:0] granted line index (registered, held)
//   pending : output [N-1:0]  current pending register
// ---------------------------------------------------------------------------
module prio_irq_encoder
   import prio_irq_pkg::*;
#(
   parameter int  N         = 8,
   parameter bit  EDGE_MODE = 1'b1,
   localparam int IDX_W     = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic             ack,
   output logic             irq,
   output logic [IDX_W-1:0] irq_id,
   output logic [N-1:0]     pending
);

   state_t           state;
   logic [N-1:0]     set;
   logic [N-1:0]     clr;
   logic [N-1:0]     pending_next;
   logic [N-1:0]     eligible;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_any;

   generate
      if (EDGE_MODE) begin : g_edge
         logic [N-1:0] req_q;

         // req_q clears on reset, so a line already high at release counts as an edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               req_q <= '0;
            end else begin
               // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
               req_q <= req;
            end
         end

         assign set = req & ~req_q;
      end else begin : g_level
         assign set = req;
      end
   endgenerate

   // Only an ack against a held grant clears anything; the grant index is stable while ACTIVE.
   assign clr          = (state == ACTIVE && ack) ? (N'(1) << irq_id) : '0;
   // set is OR'ed in last so a fresh request on the acked line is never lost.
   assign pending_next = (pending & ~clr) | set;
   assign eligible     = pending & ~mask;

   priority_encoder_param #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_enc (
      .vec (eligible),
      .idx (enc_idx),
      .any (enc_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         irq     <= 1'b0;
         irq_id  <= '0;
         pending <= '0;
      end else begin
         pending <= pending_next;
         case (state)
            IDLE: begin
               if (enc_any) begin
                  state  <= ACTIVE;
                  irq    <= 1'b1;
                  irq_id <= enc_idx;
               end
            end
            ACTIVE: begin
               // Grant is held regardless of mask/req changes; irq_id keeps its value after ack.
               if (ack) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule : prio_irq_encoder

// File: tb/tb_prio_irq_encoder.sv
// ---------------------------------------------------------------------------
// tb_prio_irq_encoder
// Bench for prio_irq_encoder: an edge-mode N=8 instance (a) and a level-mode
// N=16 instance (b) share clock and reset. Each vector row holds the inputs
// driven before a rising edge and the outputs required just after it.
// ---------------------------------------------------------------------------
module tb_prio_irq_encoder;

   typedef struct {
      bit          sel;      // 0 = instance a (edge, N=8), 1 = instance b (level, N=16)
      logic [15:0] req;
      logic [15:0] mask;
      logic        ack;
      logic        irq;
      logic [3:0]  id;
      logic [15:0] pend;
      int          row;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [7:0]  req_a, mask_a, pend_a;
   logic        ack_a, irq_a;
   logic [2:0]  id_a;

   logic [15:0] req_b, mask_b, pend_b;
   logic        ack_b, irq_b;
   logic [3:0]  id_b;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t tbl_edge[$];
   vec_t tbl_level[$];
   vec_t exp_q[$];
   int   row_cnt = 0;

   always #5 clk = ~clk;

   prio_irq_encoder #(.N(8), .EDGE_MODE(1'b1)) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_a),
      .mask    (mask_a),
      .ack     (ack_a),
      .irq     (irq_a),
      .irq_id  (id_a),
      .pending (pend_a)
   );

   prio_irq_encoder #(.N(16), .EDGE_MODE(1'b0)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_b),
      .mask    (mask_b),
      .ack     (ack_b),
      .irq     (irq_b),
      .irq_id  (id_b),
      .pending (pend_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t r(input bit sel, input logic [15:0] rq, input logic [15:0] mk,
                              input logic ak, input logic ei, input logic [3:0] eid,
                              input logic [15:0] ep);
      vec_t v;
      v.sel  = sel;
      v.req  = rq;
      v.mask = mk;
      v.ack  = ak;
      v.irq  = ei;
      v.id   = eid;
      v.pend = ep;
      v.row  = 0;
      return v;
   endfunction

   // Drive one row, queue its expectation, clock once and compare just after the edge.
   task automatic apply(input vec_t v);
      vec_t e;
      v.row = row_cnt++;
      if (!v.sel) begin
         req_a  = v.req[7:0];
         mask_a = v.mask[7:0];
         ack_a  = v.ack;
      end else begin
         req_b  = v.req;
         mask_b = v.mask;
         ack_b  = v.ack;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (!e.sel) begin
         check($sformatf("a.vec%0d irq", e.row),     {31'b0, irq_a},  {31'b0, e.irq});
         check($sformatf("a.vec%0d irq_id", e.row),  {29'b0, id_a},   {28'b0, e.id});
         check($sformatf("a.vec%0d pending", e.row), {24'b0, pend_a}, {16'b0, e.pend});
      end else begin
         check($sformatf("b.vec%0d irq", e.row),     {31'b0, irq_b},  {31'b0, e.irq});
         check($sformatf("b.vec%0d irq_id", e.row),  {28'b0, id_b},   {28'b0, e.id});
         check($sformatf("b.vec%0d pending", e.row), {16'b0, pend_b}, {16'b0, e.pend});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- vector tables ----------------
      // Release from reset with all lines high: all latched on edge 1, line 7 granted on edge 2,
      // then drained one grant per ack, highest index first.
      tbl_edge.push_back(r(0, 16'hFF, 16'h00, 1'b0, 1'b0, 4'd0, 16'hFF));
      tbl_edge.push_back(r(0, 16'hFF, 16'h00, 1'b0, 1'b1, 4'd7, 16'hFF));
      for (int i = 7; i >= 0; i--) begin
         tbl_edge.push_back(r(0, 16'hFF, 16'h00, 1'b1, 1'b0, 4'(i), 16'((1 << i) - 1)));
         if (i > 0)
            tbl_edge.push_back(r(0, 16'hFF, 16'h00, 1'b0, 1'b1, 4'(i - 1), 16'((1 << i) - 1)));
      end
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b0, 4'd0, 16'h00));
      // Priority drain of 0010_0101 -> 5, 2, 0; ack while IDLE is ignored.
      tbl_edge.push_back(r(0, 16'h25, 16'h00, 1'b0, 1'b0, 4'd0, 16'h25));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd5, 16'h25));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd5, 16'h05));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd2, 16'h05));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd2, 16'h05));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd2, 16'h01));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b1, 4'd0, 16'h01));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd0, 16'h00));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd0, 16'h00));
      // Mask: line 7 masked -> 1 granted; unmask -> 7; masking a held grant does not retract it.
      tbl_edge.push_back(r(0, 16'h82, 16'h80, 1'b0, 1'b0, 4'd0, 16'h82));
      tbl_edge.push_back(r(0, 16'h00, 16'h80, 1'b0, 1'b1, 4'd1, 16'h82));
      tbl_edge.push_back(r(0, 16'h00, 16'h80, 1'b1, 1'b0, 4'd1, 16'h80));
      tbl_edge.push_back(r(0, 16'h00, 16'h80, 1'b0, 1'b0, 4'd1, 16'h80));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd7, 16'h80));
      tbl_edge.push_back(r(0, 16'h00, 16'h80, 1'b0, 1'b1, 4'd7, 16'h80));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd7, 16'h00));
      // Hold stability: grant 3 held while line 6 arrives; then 6. Repeated edge merges.
      tbl_edge.push_back(r(0, 16'h08, 16'h00, 1'b0, 1'b0, 4'd7, 16'h08));
      tbl_edge.push_back(r(0, 16'h08, 16'h00, 1'b0, 1'b1, 4'd3, 16'h08));
      tbl_edge.push_back(r(0, 16'h48, 16'h00, 1'b0, 1'b1, 4'd3, 16'h48));
      tbl_edge.push_back(r(0, 16'h48, 16'h00, 1'b1, 1'b0, 4'd3, 16'h40));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd6, 16'h40));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd6, 16'h00));
      tbl_edge.push_back(r(0, 16'h40, 16'h00, 1'b0, 1'b0, 4'd6, 16'h40));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd6, 16'h40));
      tbl_edge.push_back(r(0, 16'h40, 16'h00, 1'b0, 1'b1, 4'd6, 16'h40));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd6, 16'h00));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b0, 4'd6, 16'h00));
      // Set/clear collision on line 4: new edge in the ack cycle keeps it pending, re-granted.
      tbl_edge.push_back(r(0, 16'h10, 16'h00, 1'b0, 1'b0, 4'd6, 16'h10));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd4, 16'h10));
      tbl_edge.push_back(r(0, 16'h10, 16'h00, 1'b1, 1'b0, 4'd4, 16'h10));
      tbl_edge.push_back(r(0, 16'h10, 16'h00, 1'b0, 1'b1, 4'd4, 16'h10));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b1, 1'b0, 4'd4, 16'h00));
      // Set up a held grant on line 0 ahead of the mid-ACTIVE reset.
      tbl_edge.push_back(r(0, 16'h01, 16'h00, 1'b0, 1'b0, 4'd4, 16'h01));
      tbl_edge.push_back(r(0, 16'h00, 16'h00, 1'b0, 1'b1, 4'd0, 16'h01));

      // Level mode, N=16: held req[12] re-granted every 2 cycles; dropped -> no regrant.
      tbl_level.push_back(r(1, 16'h1000, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h1000));
      tbl_level.push_back(r(1, 16'h1000, 16'h0000, 1'b0, 1'b1, 4'd12, 16'h1000));
      tbl_level.push_back(r(1, 16'h1000, 16'h0000, 1'b1, 1'b0, 4'd12, 16'h1000));
      tbl_level.push_back(r(1, 16'h1000, 16'h0000, 1'b0, 1'b1, 4'd12, 16'h1000));
      tbl_level.push_back(r(1, 16'h1000, 16'h0000, 1'b1, 1'b0, 4'd12, 16'h1000));
      tbl_level.push_back(r(1, 16'h1000, 16'h0000, 1'b0, 1'b1, 4'd12, 16'h1000));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd12, 16'h0000));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd12, 16'h0000));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd12, 16'h0000));
      // Level pending is sticky until acked; top line 15 beats line 0.
      tbl_level.push_back(r(1, 16'h8001, 16'h0000, 1'b0, 1'b0, 4'd12, 16'h8001));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd15, 16'h8001));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd15, 16'h0001));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0,  16'h0001));
      tbl_level.push_back(r(1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000));

      // ---------------- reset with all lines high ----------------
      rst_n  = 1'b0;
      req_a  = 8'hFF;
      mask_a = 8'h00;
      ack_a  = 1'b0;
      req_b  = 16'h0000;
      mask_b = 16'h0000;
      ack_b  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset irq",     {31'b0, irq_a},  32'd0);
      check("reset irq_id",  {29'b0, id_a},   32'd0);
      check("reset pending", {24'b0, pend_a}, 32'd0);
      check("reset b irq",   {31'b0, irq_b},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl_edge[i]) apply(tbl_edge[i]);

      // ---------------- reset while ACTIVE ----------------
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-reset irq",     {31'b0, irq_a},  32'd0);
      check("mid-reset irq_id",  {29'b0, id_a},   32'd0);
      check("mid-reset pending", {24'b0, pend_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(r(0, 16'h00, 16'h00, 1'b0, 1'b0, 4'd0, 16'h00));

      // ---------------- level-mode instance ----------------
      foreach (tbl_level[i]) apply(tbl_level[i]);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_prio_irq_encoder
